// File: rtl/bm_acc_pkg.sv
// bm_acc_pkg: shared state encoding, default widths and burst-length floor for the product accumulator
package bm_acc_pkg;
  localparam int DEF_PROD_BITS = 16;
  localparam int DEF_ACC_BITS = 20;
  localparam int DEF_CNT_BITS = 8;
  localparam int MIN_BURST = 1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACCUM = 2'd1,
    EMIT = 2'd2
  } state_t;
endpackage

// File: rtl/bm_product_accumulator_if.sv
// bm_product_accumulator_if: product-in and sum-out valid/ready streams of the product accumulator
//   prod_in/prod_valid/prod_ready/burst_len : product stream from the multiplier stage
//   sum_out/sum_valid/sum_ready/overflow    : burst sum stream to the result sink
//   master = producer/sink side, slave = accumulator side
interface bm_product_accumulator_if
  import bm_acc_pkg::*;
#(
  parameter int PROD_BITS = DEF_PROD_BITS,
  parameter int ACC_BITS = DEF_ACC_BITS,
  parameter int CNT_BITS = DEF_CNT_BITS
);
  logic [PROD_BITS-1:0] prod_in;
  logic prod_valid;
  logic prod_ready;
  logic [CNT_BITS-1:0] burst_len;
  logic [ACC_BITS-1:0] sum_out;
  logic sum_valid;
  logic sum_ready;
  logic overflow;
  modport master (
    output prod_in, prod_valid, burst_len, sum_ready,
    input prod_ready, sum_out, sum_valid, overflow
  );
  modport slave (
    input prod_in, prod_valid, burst_len, sum_ready,
    output prod_ready, sum_out, sum_valid, overflow
  );
endinterface

// File: rtl/bm_acc_sat_add.sv
// bm_acc_sat_add: accumulator adder with carry out, clamping to all-ones when BM_ACC_SATURATE_EN is defined
//   acc   : current accumulator value
//   prod  : zero-extended product
//   sum   : acc + prod (wrapped, or clamped under BM_ACC_SATURATE_EN)
//   carry : carry out of the top accumulator bit
module bm_acc_sat_add
  import bm_acc_pkg::*;
#(
  parameter int ACC_BITS = DEF_ACC_BITS
) (
  input logic [ACC_BITS-1:0] acc,
  input logic [ACC_BITS-1:0] prod,
  output logic [ACC_BITS-1:0] sum,
  output logic carry
);
  logic [ACC_BITS-1:0] raw;
  assign {carry, raw} = {1'b0, acc} + {1'b0, prod};
`ifdef BM_ACC_SATURATE_EN
  // a clamped acc plus any nonzero product carries again, so it stays clamped
  assign sum = carry ? '1 : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/bm_product_accumulator.sv
// bm_product_accumulator: sums bursts of burst_len products and emits each sum with an overflow flag
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave view of bm_product_accumulator_if (product in, sum out)
//   optional: BM_ACC_SATURATE_EN clamps the accumulator instead of wrapping
module bm_product_accumulator
  import bm_acc_pkg::*;
#(
  parameter int PROD_BITS = DEF_PROD_BITS,
  parameter int ACC_BITS = DEF_ACC_BITS,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input logic clock,
  input logic reset_n,
  bm_product_accumulator_if.slave bus
);
  state_t state, state_d;
  logic [ACC_BITS-1:0] acc, acc_nx, prod_ext, add_sum, sum_q;
  logic [CNT_BITS-1:0] count, cnt_nx, len_q, eff_len;
  logic ovf, ovf_nx, add_carry, ovf_out, rdy_q, accept, idle, last;
  bm_acc_sat_add #(.ACC_BITS(ACC_BITS)) u_add (
    .acc(acc),
    .prod(prod_ext),
    .sum(add_sum),
    .carry(add_carry)
  );
  assign prod_ext = ACC_BITS'(bus.prod_in);
  assign eff_len = bus.burst_len == '0 ? CNT_BITS'(MIN_BURST) : bus.burst_len;
  assign idle = state == IDLE;
  // rdy_q keeps prod_ready low through reset and rises on the first edge after it
  assign bus.prod_ready = rdy_q && state != EMIT;
  assign accept = bus.prod_valid && bus.prod_ready;
  assign acc_nx = idle ? prod_ext : add_sum;
  assign ovf_nx = !idle && (ovf || add_carry);
  assign cnt_nx = idle ? CNT_BITS'(1) : count + CNT_BITS'(1);
  assign last = cnt_nx == (idle ? eff_len : len_q);
  assign bus.sum_valid = state == EMIT;
  assign bus.sum_out = sum_q;
  assign bus.overflow = ovf_out;
  always_comb begin
    state_d = state;
    if (idle || state == ACCUM)
      state_d = accept ? (last ? EMIT : ACCUM) : state;
    else
      state_d = (state == EMIT && !bus.sum_ready) ? EMIT : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q <= 1'b0;
      acc <= '0;
      count <= '0;
      len_q <= '0;
      ovf <= 1'b0;
      sum_q <= '0;
      ovf_out <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        acc <= acc_nx;
        count <= cnt_nx;
        ovf <= ovf_nx;
        if (idle) len_q <= eff_len;
        if (last) begin
          sum_q <= acc_nx;
          ovf_out <= ovf_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_bm_product_accumulator.sv
// tb_bm_product_accumulator: scoreboard bench for bm_product_accumulator
module tb_bm_product_accumulator;
`ifdef BM_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [20:0] sb[$];
  int unsigned pq[$];
  int gq[$];
  bm_product_accumulator_if bus ();
  bm_product_accumulator dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input int unsigned p);
    int n = 0;
    bus.prod_in = 16'(p);
    bus.prod_valid = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.prod_ready && n < 1000);
    if (!bus.prod_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got prod_ready=0 expected 1 for product %0d", p);
    end
    @(posedge clock);
    #1 bus.prod_valid = 1'b0;
  endtask
  task automatic burst(input int len_cfg, input int len_chg);
    logic [20:0] s21;
    logic [19:0] acc;
    logic ovf;
    acc = '0;
    ovf = 1'b0;
    bus.burst_len = 8'(len_cfg);
    foreach (pq[i]) begin
      if (i == 0) acc = 20'(pq[i]);
      else begin
        s21 = {1'b0, acc} + 21'(pq[i]);
        ovf = ovf | s21[20];
        acc = (SAT && s21[20]) ? 20'hfffff : s21[19:0];
      end
    end
    sb.push_back({ovf, acc});
    foreach (pq[i]) begin
      for (int g = 0; g < (i < gq.size() ? gq[i] : 0); g++) begin
        @(posedge clock);
        #1;
      end
      send(pq[i]);
      if (i == 0 && len_chg >= 0) bus.burst_len = 8'(len_chg);
    end
  endtask
  initial forever begin
    logic [20:0] e;
    @(negedge clock);
    if (reset_n && bus.sum_valid && bus.sum_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sum: got %0d expected none", bus.sum_out);
      end else begin
        e = sb.pop_front();
        check("sum", 32'(bus.sum_out), 32'(e[19:0]));
        check("ovf", 32'(bus.overflow), 32'(e[20]));
      end
    end
  end
  initial begin
    int n;
    bus.prod_in = '0;
    bus.prod_valid = 1'b0;
    bus.burst_len = '0;
    bus.sum_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_ready", 32'(bus.prod_ready), 0);
    check("rst_valid", 32'(bus.sum_valid), 0);
    check("rst_sum", 32'(bus.sum_out), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    reset_n = 1'b1;
    #1 check("ready_before_edge", 32'(bus.prod_ready), 0);
    @(posedge clock);
    #1 check("ready_after_edge", 32'(bus.prod_ready), 1);
    pq = {10, 20, 30};
    burst(3, -1);
    check("basic_latency", 32'(bus.sum_valid), 1);
    pq = {7};
    burst(0, -1);
    check("zero_len_latency", 32'(bus.sum_valid), 1);
    pq.delete();
    repeat (20) pq.push_back(65535);
    burst(20, -1);
    @(posedge clock);
    #1 bus.sum_ready = 1'b0;
    pq = {1, 2};
    burst(2, -1);
    bus.burst_len = 8'd1;
    sb.push_back({1'b0, 20'd9});
    bus.prod_in = 16'd9;
    bus.prod_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("bp_ready", 32'(bus.prod_ready), 0);
      check("bp_hold", 32'(bus.sum_out), 3);
      check("bp_valid", 32'(bus.sum_valid), 1);
    end
    @(posedge clock);
    #1 bus.sum_ready = 1'b1;
    send(9);
    pq = {1, 2, 3, 4};
    gq = {0, 1, 0, 1};
    burst(4, 2);
    gq.delete();
    @(negedge clock);
    check("gap_sum_hold", 32'(bus.sum_out), 10);
    bus.burst_len = 8'd4;
    send(5);
    send(6);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_sum", 32'(bus.sum_out), 0);
    check("mid_rst_valid", 32'(bus.sum_valid), 0);
    check("mid_rst_ready", 32'(bus.prod_ready), 0);
    check("mid_rst_ovf", 32'(bus.overflow), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    pq = {1, 2};
    burst(2, -1);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending sums expected 0", sb.size());
    end
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bm_product_accumulator.md
Name: bm_product_accumulator

Overview:
Downstream consumer of the base multiplier's registered product stream (out0-style, 16-bit unsigned). Accepts products over a valid/ready handshake and sums a programmable burst of N products. Presents the burst sum on a second valid/ready handshake, with an overflow flag. Sits between the multiplier stage and the result sink in the multiply benchmarks.

Parameters:
PROD_BITS, 16, width of incoming unsigned product (matches 2*BITS).
ACC_BITS, 20, accumulator and sum width.
CNT_BITS, 8, width of the burst length and the internal product counter.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
prod_in  input  PROD_BITS  product from the multiplier stage.
prod_valid  input  1  prod_in is valid this cycle.
prod_ready  output  1  block accepts prod_in this cycle.
burst_len  input  CNT_BITS  number of products per sum; sampled on the first accept of a burst.
sum_out  output  ACC_BITS  burst sum, registered.
sum_valid  output  1  sum_out and overflow are valid.
sum_ready  input  1  sink accepts sum_out.
overflow  output  1  the burst sum exceeded 2^ACC_BITS-1.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; acc, count, sum_out, overflow, sum_valid = 0.
  - prod_ready=0 while reset_n is low.
  - prod_ready=1 from the first clock edge after deassertion.
- Accept event: prod_valid & prod_ready at a rising edge. Products are zero-extended to ACC_BITS.
- IDLE (prod_ready=1, sum_valid=0). On accept:
  - latch len = (burst_len==0) ? 1 : burst_len;
  - acc = prod_in, count = 1, ovf_int = 0;
  - if len==1, go to EMIT; else go to ACCUM.
- ACCUM (prod_ready=1). On accept:
  - acc = acc + prod_in; count = count + 1;
  - ovf_int |= carry out of bit ACC_BITS-1;
  - when the new count == len, go to EMIT.
  - With no accept, all state holds. Idle gaps in prod_valid are allowed mid-burst.
- EMIT:
  - Entering EMIT loads sum_out = final acc value and overflow = final ovf_int, both including the last product.
  - sum_valid=1 and prod_ready=0 (back-pressure upstream).
  - On sum_valid & sum_ready, go to IDLE. sum_valid drops on the next cycle; prod_ready rises on the same cycle.
- Latency: sum_valid asserts on the cycle after the edge that accepted the last product.
  - Minimum burst-to-burst period is len+1 cycles when sum_ready is held high.
- Stability: while sum_valid=1 and sum_ready=0, sum_out and overflow hold.
  - sum_out and overflow keep their last value after the handshake, until the next EMIT load.
- burst_len changes mid-burst are ignored; it is re-sampled only in IDLE.
- prod_in is ignored whenever prod_ready=0.
- Overflow without the optional feature: acc wraps modulo 2^ACC_BITS; overflow=1 if any addition in the burst carried out.
- Reset mid-burst: the partial sum is discarded and no sum is emitted.

Optional Feature:
BM_ACC_SATURATE_EN
- Defined: on the first carry out, acc clamps to 2^ACC_BITS-1 and stays clamped for the rest of the burst. overflow=1 as before.
- Undefined: wrap-around as described above. No saturation logic is synthesised.

Decomposition:
- Shared package bm_acc_pkg:
  - state encoding (IDLE=2'd0, ACCUM=2'd1, EMIT=2'd2);
  - default widths PROD_BITS/ACC_BITS/CNT_BITS;
  - the burst_len==0 -> 1 rule as a named constant MIN_BURST=1.
- One sub-module, bm_acc_sat_add:
  - inputs: ACC_BITS accumulator plus zero-extended product;
  - outputs: sum and carry;
  - saturation muxing under BM_ACC_SATURATE_EN.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Basic sum: burst_len=3, products 10, 20, 30 back-to-back, sum_ready=1 -> sum_out=60, overflow=0, sum_valid high one cycle after the third accept.
- Zero length: burst_len=0, product 7 -> treated as len 1; sum_out=7 the next cycle.
- Overflow: burst_len=20, all products 65535.
  - Without the macro: sum_out=262124 (1310700 mod 2^20), overflow=1.
  - With BM_ACC_SATURATE_EN: sum_out=1048575, overflow=1.
- Back-pressure: sum_ready=0 for 5 cycles in EMIT with prod_valid=1 -> prod_ready=0 throughout, sum_out stable, no product consumed. After sum_ready=1, the next burst starts with the held product.
- Gaps and len change: burst_len=4 with prod_valid toggling 1,0,1,1,0,1 over products 1,2,3,4. burst_len changes to 2 after the first accept -> sum_out=10.
- Reset mid-burst: len=4, accept 5 and 6, then pulse reset_n low mid-cycle.
  - Outputs go to 0 immediately (asynchronously); no sum_valid.
  - Next burst len=2 with 1, 2 -> sum_out=3, overflow=0.
